wb_commit: RTL
==============

// Module: wb_commit
// PURPOSE
//  Writeback-side consumer of the MEM/WB pipeline register outputs. It holds the
//  architectural HI/LO pair, the LLbit and a CP0 timer subset (Count reg 9, Compare reg 11).
//  It commits the wb_* write requests and serves forwarded reads to the EX/MEM stages.
//  It also raises the timer interrupt toward the exception logic.
// PARAMETERS
//  DATA_W     32  datapath width (`Reg)
//  COUNT_DIV  1   Count increments once every COUNT_DIV clocks (1..255)
// PORTS
//  clk               in   1       single clock; all state updates on posedge
//  rst               in   1       synchronous reset, active-high
//  wb_whilo          in   1       HI/LO write enable from MEM/WB
//  wb_hi             in   DATA_W  HI write value
//  wb_lo             in   DATA_W  LO write value
//  wb_llbit_we       in   1       LLbit write enable
//  wb_llbit_value    in   1       LLbit write value
//  wb_cp0_reg_we     in   1       CP0 write enable
//  wb_cp0_waddr      in   5       CP0 write address
//  wb_cp0_wdata      in   DATA_W  CP0 write data
//  flush             in   1       exception/eret flush from ctrl
//  cp0_raddr         in   5       CP0 read address from EX
//  hi_o, lo_o        out  DATA_W  committed HI/LO (registered, no forwarding)
//  llbit_o           out  1       LLbit, forwarded from wb_llbit_* when wb_llbit_we=1
//  cp0_rdata         out  DATA_W  CP0 read data, forwarded from the same-cycle wb write on address match
//  timer_int_o       out  1       timer interrupt (registered, level)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - hi_o=lo_o=0, LLbit=0, Count=0, Compare=0, timer_int_o=0, prescaler=0.
//   - Reset overrides every other input in the same cycle.
//  HI/LO: when wb_whilo=1, hi_o<=wb_hi and lo_o<=wb_lo on the next edge; otherwise both hold.
//  LLbit register:
//   - flush=1 -> 0, and flush beats wb_llbit_we in the same cycle.
//   - else wb_llbit_we=1 -> wb_llbit_value.
//   - llbit_o is combinational: if flush=1 then 0; elif wb_llbit_we then wb_llbit_value; else the register.
//  Prescaler:
//   - Counts 0..COUNT_DIV-1 and wraps.
//   - A tick fires on the cycle it equals COUNT_DIV-1; with COUNT_DIV=1, every cycle ticks.
//  Count:
//   - On a tick, Count<=Count+1, wrapping 0xFFFFFFFF->0.
//   - A CP0 write to reg 9 loads wb_cp0_wdata and wins over the tick in the same cycle.
//   - That write also resets the prescaler to 0.
//  Compare:
//   - A CP0 write to reg 11 loads the data and clears timer_int_o on the next edge.
//   - The clear wins over a same-cycle match.
//  Timer interrupt:
//   - Sets when Compare!=0 and the registered Count==Compare and no Compare write is in progress.
//   - Stays set (sticky) until a Compare write or reset.
//  CP0 writes:
//   - Writes to addresses other than 9/11 are ignored.
//   - flush does NOT block CP0 or HI/LO writes, because the MEM/WB stage already squashes its enables.
//  cp0_rdata (combinational):
//   - Returns wb_cp0_wdata when wb_cp0_reg_we=1 and wb_cp0_waddr==cp0_raddr.
//   - Otherwise returns the register for addresses 9/11, and 0 for any other address.
//  Latency:
//   - Committed state is visible on hi_o/lo_o one cycle after the write.
//   - llbit_o and cp0_rdata see the write in the same cycle through the forwarding path.
// STRUCTURE
//  - Constants `Rst_Enable, `Write_Enable, `Zero_Word, `Reg and the CP0 addresses CP0_COUNT=5'd9 and CP0_COMPARE=5'd11 live in define.v.
//  - One sub-module, cp0_timer (prescaler, Count, Compare, timer_int), owns the timer state.
//  - wb_commit keeps HI/LO, the LLbit and the read muxes.
// TESTING
//  1. Reset: drive random wb_* with rst=1 for 3 cycles -> all outputs 0. Release: Count reads 1 after the first post-reset edge (COUNT_DIV=1).
//  2. HI/LO: wb_whilo=1, hi=0xDEAD0001, lo=0x0000BEEF -> next cycle hi_o/lo_o hold those values. They persist while wb_whilo=0.
//  3. LLbit: wb_llbit_we=1, value=1 -> llbit_o=1 in the same cycle and after the edge. Then flush=1 with wb_llbit_we=1, value=1 -> llbit_o=0, register 0.
//  4. Timer: write Compare=5 then Count=0 -> timer_int_o rises when Count==5. It stays set through Count wrap. A Compare write of 0x20 clears it the next cycle.
//  5. Simultaneous: Count write 0x100 on a tick edge -> Count=0x100, not 0x101. A Compare write in the match cycle -> timer_int_o stays 0.
//  6. Forwarding: wb_cp0_reg_we=1, addr 11, data 0x77, cp0_raddr=11 -> cp0_rdata=0x77 the same cycle. cp0_raddr=12 -> 0.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared constants for the writeback commit slice: control polarities and the
// CP0 timer register addresses.
package wb_commit_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;

  // True when a CP0 write request targets the given register address.
  function automatic logic cp0_write_hits(input logic we, input logic [4:0] waddr,
                                          input logic [4:0] addr);
    return (we == WRITE_ENABLE) && (waddr == addr);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer subset: prescaler, Count (reg 9), Compare (reg 11) and the sticky
// level timer interrupt.
module cp0_timer
  import wb_commit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int COUNT_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cp0_we,
  input  logic [4:0]        cp0_waddr,
  input  logic [DATA_W-1:0] cp0_wdata,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare,
  output logic              timer_int
);

  localparam logic [7:0]        PRESC_LAST = 8'(COUNT_DIV - 1);
  localparam logic [DATA_W-1:0] ONE        = DATA_W'(1);

  logic [7:0] presc;
  logic       tick;
  logic       count_wr;
  logic       compare_wr;

  assign tick       = (presc == PRESC_LAST);
  assign count_wr   = cp0_write_hits(cp0_we, cp0_waddr, CP0_COUNT);
  assign compare_wr = cp0_write_hits(cp0_we, cp0_waddr, CP0_COMPARE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      presc     <= '0;
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      // A Count write restarts the prescaler so the next tick is a full period away.
      if (count_wr || tick) presc <= '0;
      else                  presc <= presc + 8'd1;

      if (count_wr)  count <= cp0_wdata;
      else if (tick) count <= count + ONE;

      if (compare_wr) compare <= cp0_wdata;

      if (compare_wr)
        timer_int <= 1'b0;
      else if ((compare != '0) && (count == compare))
        timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit: architectural HI/LO and LLbit, CP0 timer, and the forwarded
// LLbit / CP0 read paths toward EX/MEM.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int COUNT_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_llbit_we,
  input  logic              wb_llbit_value,
  input  logic              wb_cp0_reg_we,
  input  logic [4:0]        wb_cp0_waddr,
  input  logic [DATA_W-1:0] wb_cp0_wdata,
  input  logic              flush,
  input  logic [4:0]        cp0_raddr,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              llbit_o,
  output logic [DATA_W-1:0] cp0_rdata,
  output logic              timer_int_o
);

  logic              llbit_q;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] compare;

  cp0_timer #(
    .DATA_W   (DATA_W),
    .COUNT_DIV(COUNT_DIV)
  ) u_cp0_timer (
    .clk      (clk),
    .rst      (rst),
    .cp0_we   (wb_cp0_reg_we),
    .cp0_waddr(wb_cp0_waddr),
    .cp0_wdata(wb_cp0_wdata),
    .count    (count),
    .compare  (compare),
    .timer_int(timer_int_o)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_o    <= '0;
      lo_o    <= '0;
      llbit_q <= 1'b0;
    end else begin
      if (wb_whilo == WRITE_ENABLE) begin
        hi_o <= wb_hi;
        lo_o <= wb_lo;
      end
      // A flush kills any in-flight LL/SC reservation, even one being written now.
      if (flush)                               llbit_q <= 1'b0;
      else if (wb_llbit_we == WRITE_ENABLE)    llbit_q <= wb_llbit_value;
    end
  end

  // NOTE: each always_comb output gets a default first so no path through the
  // if/else chain leaves it unassigned, which would infer a latch.
  always_comb begin
    llbit_o = llbit_q;
    if (flush)                            llbit_o = 1'b0;
    else if (wb_llbit_we == WRITE_ENABLE) llbit_o = wb_llbit_value;
  end

  always_comb begin
    cp0_rdata = '0;
    if (cp0_write_hits(wb_cp0_reg_we, wb_cp0_waddr, cp0_raddr))
      cp0_rdata = wb_cp0_wdata;
    else if (cp0_raddr == CP0_COUNT)
      cp0_rdata = count;
    else if (cp0_raddr == CP0_COMPARE)
      cp0_rdata = compare;
  end

endmodule
